calc_driver: RTL and testbench
==============================

# calc_driver

Command sequencer for the calculator block that sits on the calculator's input side. It accepts one complete calculation (operand A, op code, optional operand B) over a ready/valid command port. It serialises the calculation into the calculator's entry protocol: a `validIn` rising edge with `dataIn` stable marks each token. After a settle window it captures the calculator's `dataOut` and returns it as a one-cycle result pulse. It lets test harnesses and upstream control logic issue whole calculations without hand-timing enter pulses.

## Interface
- `PULSE_LEN`, 2: cycles `validOut` is held high per token; legal range 1..15.
- `GAP_LEN`, 2: cycles `validOut` is held low between tokens; legal range 1..15.
- `SETTLE_LEN`, 2: low cycles after the last token before `resultIn` is sampled; legal range 1..15.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmdValid` in 1: command present.
- `cmdReady` out 1: driver idle; command accepted on the edge where `cmdValid & cmdReady`.
- `cmdA` in 8: first operand.
- `cmdOp` in 3: op code. 0 mul, 1 add, 2 sub (binary); 3 square, 4 +2, 5 −2 (unary); 6, 7 illegal.
- `cmdB` in 8: second operand; ignored for unary ops.
- `validOut` out 1: drives the calculator's `validIn`.
- `dataOut` out 8: drives the calculator's `dataIn`.
- `resultIn` in 8: from the calculator's `dataOut`.
- `resultValid` out 1: one-cycle pulse; `result` is valid in that cycle.
- `result` out 8: captured calculation result; holds until the next capture.
- `err` out 1: one-cycle pulse on an illegal op code.

## Operation
- States: IDLE, DRIVE, GAP, SETTLE, DONE, ERR.
- Reset values: state IDLE, `validOut` 0, `dataOut` 0, `result` 0, `resultValid` 0, `err` 0. `cmdReady` is forced 0 while `rst` is high.
- `cmdReady` = (state == IDLE) and not `rst`.
- On accept, `cmdA`, `cmdOp` and `cmdB` are latched into internal registers. Token count N = 3 for op 0..2, N = 2 for op 3..5.
- Illegal op 6 or 7: go to ERR. `err` is high for one cycle, then IDLE. No `validOut` activity, `result` unchanged, no `resultValid`.
- Token sequence: A, then op (zero-extended to 8 bits), then B (binary ops only).
- IDLE → DRIVE on a legal accept.
- DRIVE: `validOut` = 1 and `dataOut` = current token, both stable for PULSE_LEN cycles.
  - If more tokens remain → GAP.
  - If it was the last token → SETTLE.
- GAP: `validOut` = 0 and `dataOut` holds the previous token for GAP_LEN cycles, then → DRIVE with the next token.
- SETTLE: `validOut` = 0 for SETTLE_LEN cycles. On the last SETTLE edge `result` ← `resultIn`, and the state goes to DONE.
- DONE: `resultValid` = 1 for one cycle, then → IDLE.
- `cmdValid` while busy is ignored; held command inputs have no effect until the next accept.
- No arithmetic happens in the driver; `result` is the calculator's 8-bit wrapped value as delivered.

## Timing
- Call the accept edge cycle 0. `validOut` rises in cycle 1, carrying `dataOut` = A.
- `resultValid` cycle = N·PULSE_LEN + (N−1)·GAP_LEN + SETTLE_LEN + 1.
  - With default parameters: binary → cycle 13, unary → cycle 9, ERR → `err` in cycle 1.
- `cmdReady` returns high in the cycle after `resultValid` (or after `err`). The earliest next accept is therefore that cycle.
- Between commands `validOut` is low for at least SETTLE_LEN + 1 cycles, so every token produces a fresh rising edge.
- Reset mid-operation: at the first edge with `rst` high, all outputs take their reset values and the state returns to IDLE. The latched command is discarded.
- The calculator's `rst` must be asserted in the same cycles as this block's `rst`; otherwise the two token counts desynchronise. This is a system integration rule.
- `rst` and `cmdValid` high in the same cycle: reset wins and no accept occurs.

## Structure
- Shared package `calc_pkg` holds:
  - op code constants `OP_MUL` = 0, `OP_ADD` = 1, `OP_SUB` = 2, `OP_SQR` = 3, `OP_INC2` = 4, `OP_DEC2` = 5;
  - an `is_binary`/`is_legal` helper;
  - this block's state encoding.
- Sub-module `calc_tick_timer`: a 4-bit loadable down-counter with a `done` flag, reused for the PULSE, GAP and SETTLE intervals.
- A 2-bit token index selects among the latched A, op and B.

## Test plan
- Add 7 + 5 (op 1) against the real calculator, default parameters → `validOut` high in cycles 1–2, 5–6, 9–10; `resultValid` in cycle 13 with `result` = 12.
- Mul 20 × 20 (op 0) → `result` = 144 (400 mod 256); sub 3 − 5 (op 2) → `result` = 254.
- Unary: A = 9, op 3 → exactly two `validOut` pulses, `resultValid` in cycle 9 with `result` = 81; then A = 0, op 5 → `result` = 254.
- Illegal op 6 → `err` in cycle 1, `validOut` never rises, `result` unchanged, `cmdReady` high in cycle 2.
- Reset in cycle 6 of a binary command (both blocks reset) → `validOut` = 0 from the next cycle. A following 2 + 2 (op 1) command yields 4.
- Back-to-back: `cmdValid` held high with two commands → the second is accepted only in the cycle after the first `resultValid`, and both results are correct.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: op codes, op classification helpers and driver state encoding
package calc_pkg;
  localparam logic [2:0] OP_MUL  = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_SQR  = 3'd3;
  localparam logic [2:0] OP_INC2 = 3'd4;
  localparam logic [2:0] OP_DEC2 = 3'd5;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_GAP,
    ST_SETTLE,
    ST_DONE,
    ST_ERR
  } state_t;
  function automatic logic is_binary(input logic [2:0] op);
    return op <= OP_SUB;
  endfunction
  function automatic logic is_legal(input logic [2:0] op);
    return op <= OP_DEC2;
  endfunction
endpackage

// File: rtl/calc_tick_timer.sv
// calc_tick_timer: 4-bit loadable down-counter, done while the count is zero
module calc_tick_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       done
);
  logic [3:0] cnt;
  assign done = cnt == 4'd0;
  always_ff @(posedge clk) begin
    if (rst) cnt <= 4'd0;
    else if (load) cnt <= load_val;
    else if (!done) cnt <= cnt - 4'd1;
  end
endmodule

// File: rtl/calc_driver.sv
// calc_driver: serialises one calculation into validIn/dataIn tokens and captures the result
module calc_driver
  import calc_pkg::*;
#(
  parameter int PULSE_LEN  = 2,
  parameter int GAP_LEN    = 2,
  parameter int SETTLE_LEN = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmdValid,
  output logic       cmdReady,
  input  logic [7:0] cmdA,
  input  logic [2:0] cmdOp,
  input  logic [7:0] cmdB,
  output logic       validOut,
  output logic [7:0] dataOut,
  input  logic [7:0] resultIn,
  output logic       resultValid,
  output logic [7:0] result,
  output logic       err
);
  localparam logic [3:0] P_LD = 4'(PULSE_LEN - 1);
  localparam logic [3:0] G_LD = 4'(GAP_LEN - 1);
  localparam logic [3:0] S_LD = 4'(SETTLE_LEN - 1);
  state_t state;
  logic [7:0] a_q, b_q;
  logic [2:0] op_q;
  logic [1:0] idx;
  logic t_done, t_load, accept, last, busy;
  logic [3:0] t_val;
  logic [7:0] token;
  assign cmdReady = state == ST_IDLE && !rst;
  assign accept   = cmdValid && cmdReady;
  assign last     = idx == (is_binary(op_q) ? 2'd2 : 2'd1);
  assign token    = idx == 2'd0 ? a_q : idx == 2'd1 ? {5'd0, op_q} : b_q;
  assign busy     = state == ST_DRIVE || state == ST_GAP || state == ST_SETTLE;
  // Each interval is timed by reloading with (length - 1) on entry to the next phase.
  assign t_load   = (accept && is_legal(cmdOp)) || (busy && t_done);
  assign t_val    = state == ST_DRIVE ? (last ? S_LD : G_LD) : P_LD;
  calc_tick_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (t_load),
    .load_val(t_val),
    .done    (t_done)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      validOut    <= 1'b0;
      dataOut     <= 8'd0;
      result      <= 8'd0;
      resultValid <= 1'b0;
      err         <= 1'b0;
      idx         <= 2'd0;
      a_q         <= 8'd0;
      b_q         <= 8'd0;
      op_q        <= 3'd0;
    end else begin
      resultValid <= 1'b0;
      err         <= 1'b0;
      case (state)
        ST_IDLE: if (accept) begin
          a_q  <= cmdA;
          b_q  <= cmdB;
          op_q <= cmdOp;
          idx  <= 2'd0;
          if (is_legal(cmdOp)) begin
            state    <= ST_DRIVE;
            validOut <= 1'b1;
            dataOut  <= cmdA;
          end else begin
            state <= ST_ERR;
            err   <= 1'b1;
          end
        end
        ST_DRIVE: if (t_done) begin
          validOut <= 1'b0;
          idx      <= idx + 2'd1;
          state    <= last ? ST_SETTLE : ST_GAP;
        end
        ST_GAP: if (t_done) begin
          validOut <= 1'b1;
          dataOut  <= token;
          state    <= ST_DRIVE;
        end
        ST_SETTLE: if (t_done) begin
          result      <= resultIn;
          resultValid <= 1'b1;
          state       <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_calc_driver.sv
// tb_calc_driver: table-driven check of calc_driver against a behavioural calculator
module tb_calc_driver;
  logic clk = 1'b0, rst = 1'b1, cmdValid = 1'b0, cmdReady;
  logic [7:0] cmdA = 8'd0, cmdB = 8'd0, dataOut, resultIn, result;
  logic [2:0] cmdOp = 3'd0;
  logic validOut, resultValid, err;
  int pass_cnt = 0, total_cnt = 0;

  calc_driver dut (
    .clk(clk), .rst(rst), .cmdValid(cmdValid), .cmdReady(cmdReady),
    .cmdA(cmdA), .cmdOp(cmdOp), .cmdB(cmdB), .validOut(validOut),
    .dataOut(dataOut), .resultIn(resultIn), .resultValid(resultValid),
    .result(result), .err(err)
  );

  always #5 clk = ~clk;

  // Calculator stand-in: one token per validIn rising edge, result on resultIn
  logic prev_v;
  logic [1:0] k;
  logic [7:0] ta;
  logic [2:0] top;
  logic [7:0] calc_q;
  assign resultIn = calc_q;

  function automatic logic [7:0] unop(input logic [7:0] a, input logic [2:0] op);
    return op == 3'd3 ? 8'(a * a) : op == 3'd4 ? 8'(a + 8'd2) : 8'(a - 8'd2);
  endfunction
  function automatic logic [7:0] binop(input logic [7:0] a, input logic [2:0] op, input logic [7:0] b);
    return op == 3'd0 ? 8'(a * b) : op == 3'd1 ? 8'(a + b) : 8'(a - b);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      prev_v <= 1'b0;
      k      <= 2'd0;
      calc_q <= 8'd0;
    end else begin
      prev_v <= validOut;
      if (validOut && !prev_v) begin
        if (k == 2'd0) begin
          ta <= dataOut;
          k  <= 2'd1;
        end else if (k == 2'd1) begin
          top <= dataOut[2:0];
          if (dataOut >= 8'd3) begin
            calc_q <= unop(ta, dataOut[2:0]);
            k      <= 2'd0;
          end else k <= 2'd2;
        end else begin
          calc_q <= binop(ta, top, dataOut);
          k      <= 2'd0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [2:0]  op;
    logic [7:0]  b;
    logic [7:0]  res;
    logic        er;
    int          cyc;
    logic [15:0] mask;
  } vec_t;
  vec_t vt[9];

  task automatic run(input vec_t v);
    int c;
    logic [15:0] m;
    bit seen;
    @(negedge clk);
    chk("ready_before", cmdReady, 1);
    cmdA = v.a; cmdOp = v.op; cmdB = v.b; cmdValid = 1'b1;
    @(posedge clk);
    #1 cmdValid = 1'b0;
    m = 16'd0;
    seen = 1'b0;
    for (c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c < 16) m[c] = validOut;
      if (resultValid || err) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_cycle", seen ? c : 0, v.cyc);
    chk("err_flag", err, v.er);
    chk("result_valid", resultValid, !v.er);
    chk("result", result, v.res);
    chk("valid_mask", m, v.mask);
    @(negedge clk);
    chk("ready_after", cmdReady, 1);
    chk("pulse_one_cycle", resultValid | err, 0);
  endtask

  initial begin
    vt[0] = '{8'd7,   3'd1, 8'd5,  8'd12,  1'b0, 13, 16'h0666};
    vt[1] = '{8'd20,  3'd0, 8'd20, 8'd144, 1'b0, 13, 16'h0666};
    vt[2] = '{8'd3,   3'd2, 8'd5,  8'd254, 1'b0, 13, 16'h0666};
    vt[3] = '{8'd9,   3'd3, 8'd77, 8'd81,  1'b0, 9,  16'h0066};
    vt[4] = '{8'd0,   3'd5, 8'd0,  8'd254, 1'b0, 9,  16'h0066};
    vt[5] = '{8'd6,   3'd6, 8'd1,  8'd254, 1'b1, 1,  16'h0000};
    vt[6] = '{8'd255, 3'd4, 8'd9,  8'd1,   1'b0, 9,  16'h0066};
    vt[7] = '{8'd4,   3'd7, 8'd4,  8'd1,   1'b1, 1,  16'h0000};
    vt[8] = '{8'd200, 3'd1, 8'd100,8'd44,  1'b0, 13, 16'h0666};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", cmdReady, 0);
    chk("rst_valid", validOut, 0);
    chk("rst_data", dataOut, 0);
    chk("rst_result", result, 0);
    chk("rst_rv", resultValid, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) run(vt[i]);

    // Reset during cycle 6 of a binary command
    @(negedge clk);
    cmdA = 8'd1; cmdOp = 3'd1; cmdB = 8'd1; cmdValid = 1'b1;
    @(posedge clk);
    #1 cmdValid = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid_valid_before", validOut, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_valid_after", validOut, 0);
    chk("mid_data_after", dataOut, 0);
    chk("mid_result_after", result, 0);
    chk("mid_ready_in_rst", cmdReady, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_ready_idle", cmdReady, 1);
    run('{8'd2, 3'd1, 8'd2, 8'd4, 1'b0, 13, 16'h0666});

    // Reset and cmdValid together: reset wins
    @(negedge clk);
    rst = 1'b1; cmdValid = 1'b1; cmdA = 8'd3; cmdOp = 3'd1; cmdB = 8'd3;
    #1 chk("rstcmd_ready", cmdReady, 0);
    @(posedge clk);
    #1 rst = 1'b0; cmdValid = 1'b0;
    @(negedge clk);
    chk("rstcmd_valid1", validOut, 0);
    chk("rstcmd_ready_idle", cmdReady, 1);
    @(negedge clk);
    chk("rstcmd_valid2", validOut, 0);

    // Back-to-back with cmdValid held high
    begin
      int c, rv_c, busy_ready;
      @(negedge clk);
      cmdA = 8'd3; cmdOp = 3'd1; cmdB = 8'd4; cmdValid = 1'b1;
      @(posedge clk);
      #1 cmdA = 8'd5; cmdOp = 3'd0; cmdB = 8'd6;
      rv_c = 0;
      busy_ready = 0;
      for (c = 1; c <= 40; c++) begin
        @(negedge clk);
        if (resultValid) begin
          rv_c = c;
          break;
        end
        if (cmdReady) busy_ready++;
      end
      chk("b2b_first_cycle", rv_c, 13);
      chk("b2b_first_result", result, 7);
      chk("b2b_ready_while_busy", busy_ready, 0);
      chk("b2b_ready_when_done", cmdReady, 0);
      @(negedge clk);
      chk("b2b_ready_next", cmdReady, 1);
      @(posedge clk);
      #1 cmdValid = 1'b0;
      @(negedge clk);
      chk("b2b_second_valid", validOut, 1);
      chk("b2b_second_data", dataOut, 5);
      rv_c = 0;
      for (c = 2; c <= 40; c++) begin
        @(negedge clk);
        if (resultValid) begin
          rv_c = c;
          break;
        end
      end
      chk("b2b_second_cycle", rv_c, 13);
      chk("b2b_second_result", result, 30);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
